// File: rtl/bids22_host_ctrl.sv
// Auction session sequencer: config burst, lock, N timed bid rounds with result capture, unlock.
// Outputs registered; config commands stall while ready=0; rounds end on roundOver or a bounded wait.
module bids22_host_ctrl #(
  parameter int DATA_W  = 32,
  parameter int RLEN_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              go,
  input  logic [DATA_W-1:0] cfg_x_bal,
  input  logic [DATA_W-1:0] cfg_y_bal,
  input  logic [DATA_W-1:0] cfg_z_bal,
  input  logic [2:0]        cfg_mask,
  input  logic [DATA_W-1:0] cfg_timer,
  input  logic [DATA_W-1:0] cfg_cost,
  input  logic [DATA_W-1:0] cfg_key,
  input  logic [RLEN_W-1:0] cfg_round_len,
  input  logic [7:0]        cfg_num_rounds,
  input  logic              ready,
  input  logic              roundOver,
  input  logic [DATA_W-1:0] maxBid,
  input  logic              X_win,
  input  logic              Y_win,
  input  logic              Z_win,
  input  logic [2:0]        err,
  output logic [3:0]        C_op,
  output logic [DATA_W-1:0] C_data,
  output logic              C_start,
  output logic              busy,
  output logic              res_valid,
  output logic [1:0]        res_winner,
  output logic [DATA_W-1:0] res_amt,
  output logic [2:0]        res_err,
  output logic [7:0]        res_round,
  output logic              timeout,
  output logic              done
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CFG    = 3'd1;
  localparam logic [2:0] S_ARM    = 3'd2;
  localparam logic [2:0] S_ROUND  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_UNLOCK = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  localparam logic [3:0] OP_NOOP   = 4'd0;
  localparam logic [3:0] OP_UNLOCK = 4'd1;
  localparam logic [3:0] OP_LOCK   = 4'd2;
  localparam logic [3:0] OP_LOADX  = 4'd3;
  localparam logic [3:0] OP_LOADY  = 4'd4;
  localparam logic [3:0] OP_LOADZ  = 4'd5;
  localparam logic [3:0] OP_MASK   = 4'd6;
  localparam logic [3:0] OP_TIMER  = 4'd7;
  localparam logic [3:0] OP_COST   = 4'd8;

  logic [2:0]        state;
  logic [2:0]        cfg_idx;
  logic [RLEN_W-1:0] len_cnt;
  logic [TW-1:0]     wait_cnt;
  logic [7:0]        round_idx;

  logic [DATA_W-1:0] sh_x, sh_y, sh_z, sh_timer, sh_cost, sh_key;
  logic [2:0]        sh_mask;
  logic [RLEN_W-1:0] sh_len;
  logic [7:0]        sh_rounds;

  logic [3:0]        cmd_op;
  logic [DATA_W-1:0] cmd_dat;
  logic [RLEN_W-1:0] len_eff;
  logic [7:0]        rounds_eff;
  logic              last_round;
  logic [1:0]        winner;

  // cfg_idx counts commands already placed on the bus; 7 means Lock is showing
  always_comb begin
    cmd_op  = OP_NOOP;
    cmd_dat = '0;
    case (cfg_idx)
      3'd0: begin cmd_op = OP_LOADX; cmd_dat = sh_x; end
      3'd1: begin cmd_op = OP_LOADY; cmd_dat = sh_y; end
      3'd2: begin cmd_op = OP_LOADZ; cmd_dat = sh_z; end
      3'd3: begin cmd_op = OP_MASK;  cmd_dat = {{(DATA_W-3){1'b0}}, sh_mask}; end
      3'd4: begin cmd_op = OP_TIMER; cmd_dat = sh_timer; end
      3'd5: begin cmd_op = OP_COST;  cmd_dat = sh_cost; end
      3'd6: begin cmd_op = OP_LOCK;  cmd_dat = sh_key; end
      default: begin cmd_op = OP_NOOP; cmd_dat = '0; end
    endcase
  end

  always_comb begin
    len_eff    = (sh_len == '0) ? RLEN_W'(1) : sh_len;
    rounds_eff = (sh_rounds == 8'd0) ? 8'd1 : sh_rounds;
    last_round = ({1'b0, round_idx} + 9'd1) >= {1'b0, rounds_eff};
    winner     = X_win ? 2'd1 : (Y_win ? 2'd2 : (Z_win ? 2'd3 : 2'd0));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cfg_idx    <= '0;
      len_cnt    <= '0;
      wait_cnt   <= '0;
      round_idx  <= '0;
      sh_x       <= '0;
      sh_y       <= '0;
      sh_z       <= '0;
      sh_timer   <= '0;
      sh_cost    <= '0;
      sh_key     <= '0;
      sh_mask    <= '0;
      sh_len     <= '0;
      sh_rounds  <= '0;
      C_op       <= OP_NOOP;
      C_data     <= '0;
      C_start    <= 1'b0;
      busy       <= 1'b0;
      res_valid  <= 1'b0;
      res_winner <= '0;
      res_amt    <= '0;
      res_err    <= '0;
      res_round  <= '0;
      timeout    <= 1'b0;
      done       <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go && ready) begin
            sh_x      <= cfg_x_bal;
            sh_y      <= cfg_y_bal;
            sh_z      <= cfg_z_bal;
            sh_mask   <= cfg_mask;
            sh_timer  <= cfg_timer;
            sh_cost   <= cfg_cost;
            sh_key    <= cfg_key;
            sh_len    <= cfg_round_len;
            sh_rounds <= cfg_num_rounds;
            busy      <= 1'b1;
            timeout   <= 1'b0;
            cfg_idx   <= '0;
            round_idx <= '0;
            state     <= S_CFG;
          end
        end
        S_CFG: begin
          // nothing is on the bus yet at index 0, so the first command needs no ready
          if (cfg_idx == 3'd0 || ready) begin
            if (cfg_idx == 3'd7) begin
              C_op   <= OP_NOOP;
              C_data <= '0;
              state  <= S_ARM;
            end else begin
              C_op    <= cmd_op;
              C_data  <= cmd_dat;
              cfg_idx <= cfg_idx + 3'd1;
            end
          end
        end
        S_ARM, S_GAP: begin
          C_start <= 1'b1;
          len_cnt <= RLEN_W'(1);
          state   <= S_ROUND;
        end
        S_ROUND: begin
          if (len_cnt >= len_eff) begin
            C_start  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end else begin
            len_cnt <= len_cnt + RLEN_W'(1);
          end
        end
        S_WAIT: begin
          if (roundOver) begin
            res_valid  <= 1'b1;
            res_winner <= winner;
            res_amt    <= maxBid;
            res_err    <= err;
            res_round  <= round_idx;
            if (last_round) begin
              C_op   <= OP_UNLOCK;
              C_data <= sh_key;
              state  <= S_UNLOCK;
            end else begin
              round_idx <= round_idx + 8'd1;
              state     <= S_GAP;
            end
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            timeout <= 1'b1;
            C_op    <= OP_UNLOCK;
            C_data  <= sh_key;
            state   <= S_UNLOCK;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_UNLOCK: begin
          C_op   <= OP_NOOP;
          C_data <= '0;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bids22_host_ctrl.sv
// Scoreboard bench for bids22_host_ctrl: expected per-cycle output records queued by stimulus,
// popped and compared by a negedge monitor whenever the DUT shows activity.
module tb_bids22_host_ctrl;
  localparam int DW = 32;
  localparam logic [DW-1:0] KEY = 32'hCAFE_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n = 1'b0;
  logic          go = 1'b0;
  logic [DW-1:0] cfg_x_bal = 32'd100, cfg_y_bal = 32'd200, cfg_z_bal = 32'd300;
  logic [2:0]    cfg_mask = 3'b101;
  logic [DW-1:0] cfg_timer = 32'd10, cfg_cost = 32'd1, cfg_key = KEY;
  logic [15:0]   cfg_round_len = 16'd4;
  logic [7:0]    cfg_num_rounds = 8'd1;
  logic          ready = 1'b1, roundOver = 1'b0;
  logic [DW-1:0] maxBid = '0;
  logic          X_win = 1'b0, Y_win = 1'b0, Z_win = 1'b0;
  logic [2:0]    err = '0;
  logic [3:0]    C_op;
  logic [DW-1:0] C_data;
  logic          C_start, busy, res_valid, timeout, done;
  logic [1:0]    res_winner;
  logic [DW-1:0] res_amt;
  logic [2:0]    res_err;
  logic [7:0]    res_round;

  bids22_host_ctrl #(.DATA_W(DW), .RLEN_W(16), .TIMEOUT(64)) dut (
    .clk(clk), .reset_n(reset_n), .go(go),
    .cfg_x_bal(cfg_x_bal), .cfg_y_bal(cfg_y_bal), .cfg_z_bal(cfg_z_bal),
    .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_cost(cfg_cost), .cfg_key(cfg_key),
    .cfg_round_len(cfg_round_len), .cfg_num_rounds(cfg_num_rounds),
    .ready(ready), .roundOver(roundOver), .maxBid(maxBid),
    .X_win(X_win), .Y_win(Y_win), .Z_win(Z_win), .err(err),
    .C_op(C_op), .C_data(C_data), .C_start(C_start), .busy(busy),
    .res_valid(res_valid), .res_winner(res_winner), .res_amt(res_amt),
    .res_err(res_err), .res_round(res_round), .timeout(timeout), .done(done)
  );

  typedef struct packed {
    int          cyc;
    logic [3:0]  op;
    logic [31:0] data;
    logic        cs;
    logic        rv;
    logic [1:0]  win;
    logic [31:0] amt;
    logic [2:0]  er;
    logic [7:0]  rd;
    logic        dn;
  } rec_t;

  rec_t q[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic ev(input int c, input logic [3:0] op, input logic [31:0] d, input logic cs,
                    input logic rv, input logic [1:0] win, input logic [31:0] amt,
                    input logic [2:0] er, input logic [7:0] rd, input logic dn);
    rec_t r;
    r = '{cyc: c, op: op, data: d, cs: cs, rv: rv, win: win, amt: amt, er: er, rd: rd, dn: dn};
    q.push_back(r);
  endtask

  task automatic ev_cmd(input int c, input logic [3:0] op, input logic [31:0] d);
    ev(c, op, d, 1'b0, 1'b0, 2'd0, 32'd0, 3'd0, 8'd0, 1'b0);
  endtask

  task automatic ev_cs(input int c);
    ev(c, 4'd0, 32'd0, 1'b1, 1'b0, 2'd0, 32'd0, 3'd0, 8'd0, 1'b0);
  endtask

  task automatic ev_res(input int c, input logic [3:0] op, input logic [31:0] d,
                        input logic [1:0] win, input logic [31:0] amt, input logic [2:0] er,
                        input logic [7:0] rd);
    ev(c, op, d, 1'b0, 1'b1, win, amt, er, rd, 1'b0);
  endtask

  task automatic ev_done(input int c);
    ev(c, 4'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 3'd0, 8'd0, 1'b1);
  endtask

  // Config burst for the default cfg values; stall = extra cycles LoadY is held
  task automatic exp_cfg(input int g, input int stall);
    ev_cmd(g + 1, 4'd3, 32'd100);
    for (int k = 0; k <= stall; k++) ev_cmd(g + 2 + k, 4'd4, 32'd200);
    ev_cmd(g + stall + 3, 4'd5, 32'd300);
    ev_cmd(g + stall + 4, 4'd6, {29'd0, cfg_mask});
    ev_cmd(g + stall + 5, 4'd7, 32'd10);
    ev_cmd(g + stall + 6, 4'd8, 32'd1);
    ev_cmd(g + stall + 7, 4'd2, KEY);
  endtask

  always @(negedge clk) begin
    rec_t obs, e;
    if (C_op != 4'd0 || C_start || res_valid || done) begin
      obs = '{cyc: cyc, op: C_op, data: C_data, cs: C_start, rv: res_valid,
              win: res_valid ? res_winner : 2'd0, amt: res_valid ? res_amt : 32'd0,
              er: res_valid ? res_err : 3'd0, rd: res_valid ? res_round : 8'd0, dn: done};
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL event_unexpected cyc=%0d op=%0d data=%h cs=%b rv=%b done=%b",
                 cyc, C_op, C_data, C_start, res_valid, done);
      end else begin
        e = q.pop_front();
        if (obs != e) begin
          errors++;
          $display("FAIL event got cyc=%0d op=%0d data=%h cs=%b rv=%b win=%0d amt=%h err=%0d rd=%0d done=%b | exp cyc=%0d op=%0d data=%h cs=%b rv=%b win=%0d amt=%h err=%0d rd=%0d done=%b",
                   obs.cyc, obs.op, obs.data, obs.cs, obs.rv, obs.win, obs.amt, obs.er, obs.rd, obs.dn,
                   e.cyc, e.op, e.data, e.cs, e.rv, e.win, e.amt, e.er, e.rd, e.dn);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int at);
    while (cyc < at) tick();
  endtask

  task automatic start(output int g);
    go = 1'b1;
    tick();
    go = 1'b0;
    g = cyc;
  endtask

  task automatic pulse_ro(input int at, input logic x, input logic y, input logic z,
                          input logic [31:0] amt, input logic [2:0] e);
    wait_cyc(at);
    roundOver = 1'b1; X_win = x; Y_win = y; Z_win = z; maxBid = amt; err = e;
    tick();
    roundOver = 1'b0; X_win = 1'b0; Y_win = 1'b0; Z_win = 1'b0; maxBid = '0; err = '0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done) begin
        seen = 1'b1;
        check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_wait got=no_done exp=done within %0d cycles", name, budget);
    end
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_c_op", {28'd0, C_op}, 32'd0);
    check("rst_c_data", C_data, 32'd0);
    check("rst_flags", {26'd0, C_start, busy, res_valid, timeout, done, 1'b0}, 32'd0);
    check("rst_res", {res_winner, res_err, res_round}, 32'd0);

    // Single round, Y wins
    start(g);
    check("s1_busy", {31'd0, busy}, 32'd1);
    exp_cfg(g, 0);
    for (int k = 9; k <= 12; k++) ev_cs(g + k);
    ev_res(g + 16, 4'd1, KEY, 2'd2, 32'h50, 3'd0, 8'd0);
    ev_done(g + 17);
    pulse_ro(g + 15, 1'b0, 1'b1, 1'b0, 32'h50, 3'd0);
    wait_done("s1", 40);

    // Three rounds, stray roundOver in ROUND, go while busy
    cfg_round_len = 16'd2; cfg_num_rounds = 8'd3;
    start(g);
    exp_cfg(g, 0);
    ev_cs(g + 9);  ev_cs(g + 10);
    ev_res(g + 13, 4'd0, 32'd0, 2'd1, 32'h11, 3'd0, 8'd0);
    ev_cs(g + 14); ev_cs(g + 15);
    ev_res(g + 17, 4'd0, 32'd0, 2'd3, 32'h22, 3'd0, 8'd1);
    ev_cs(g + 18); ev_cs(g + 19);
    ev_res(g + 22, 4'd1, KEY, 2'd0, 32'h33, 3'd6, 8'd2);
    ev_done(g + 23);
    wait_cyc(g + 5); go = 1'b1; tick(); go = 1'b0;
    pulse_ro(g + 9, 1'b1, 1'b0, 1'b0, 32'hDEAD, 3'd7);
    pulse_ro(g + 12, 1'b1, 1'b1, 1'b1, 32'h11, 3'd0);
    pulse_ro(g + 16, 1'b0, 1'b0, 1'b1, 32'h22, 3'd0);
    pulse_ro(g + 21, 1'b0, 1'b0, 1'b0, 32'h33, 3'd6);
    wait_done("s2", 30);

    // Timeout, round_len 0 means one C_start cycle
    cfg_round_len = 16'd0; cfg_num_rounds = 8'd2;
    start(g);
    exp_cfg(g, 0);
    ev_cs(g + 9);
    ev_cmd(g + 74, 4'd1, KEY);
    ev_done(g + 75);
    wait_done("s3", 120);
    check("s3_timeout_sticky", {31'd0, timeout}, 32'd1);

    // go with ready low is ignored
    ready = 1'b0;
    go = 1'b1; tick(); go = 1'b0;
    tick();
    check("go_ready_low_busy", {31'd0, busy}, 32'd0);
    ready = 1'b1;
    tick();

    // ready stall while LoadY on the bus
    cfg_round_len = 16'd1; cfg_num_rounds = 8'd1;
    start(g);
    check("s4_timeout_cleared", {31'd0, timeout}, 32'd0);
    exp_cfg(g, 3);
    ev_cs(g + 12);
    ev_res(g + 14, 4'd1, KEY, 2'd1, 32'h77, 3'd0, 8'd0);
    ev_done(g + 15);
    wait_cyc(g + 2); ready = 1'b0;
    wait_cyc(g + 5); ready = 1'b1;
    pulse_ro(g + 13, 1'b1, 1'b0, 1'b1, 32'h77, 3'd0);
    wait_done("s4", 30);

    // Reset during ROUND, then a clean restart
    cfg_round_len = 16'd4;
    start(g);
    exp_cfg(g, 0);
    ev_cs(g + 9); ev_cs(g + 10);
    wait_cyc(g + 10);
    reset_n = 1'b0;
    tick();
    check("s5_rst_cstart", {31'd0, C_start}, 32'd0);
    check("s5_rst_busy", {31'd0, busy}, 32'd0);
    check("s5_rst_c_op", {28'd0, C_op}, 32'd0);
    reset_n = 1'b1;
    repeat (3) tick();

    start(g);
    exp_cfg(g, 0);
    for (int k = 9; k <= 12; k++) ev_cs(g + k);
    ev_res(g + 16, 4'd1, KEY, 2'd2, 32'h50, 3'd0, 8'd0);
    ev_done(g + 17);
    pulse_ro(g + 15, 1'b0, 1'b1, 1'b0, 32'h50, 3'd0);
    wait_done("s6", 40);

    repeat (5) tick();
    check("scoreboard_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
